// File: rtl/seq_byte_fifo_supported.sv
// First-word-fall-through FIFO with valid/ready on both sides, occupancy output
// and a sticky flag recording any write attempted while full.
module seq_byte_fifo_supported #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       in_ready,
   output logic                       out_valid,
   output logic [WIDTH-1:0]           out_data,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       ovf
);

   localparam int unsigned AW     = $clog2(DEPTH);
   localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             r_ovf;
   logic             w_push;
   logic             w_pop;

   // Handshake qualifiers come from registered occupancy only, so a full FIFO
   // never accepts a write even when the consumer pops in the same cycle.
   always_comb begin
      in_ready  = (r_count != C_FULL);
      out_valid = (r_count != '0);
      w_push    = in_valid & in_ready;
      w_pop     = out_valid & out_ready;
      out_data  = r_mem[r_rd_ptr];
      count     = r_count;
      ovf       = r_ovf;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (in_valid && !in_ready) begin
            r_ovf <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (r_count <= C_FULL);
         assert (!(w_pop && r_count == '0));
         assert (!(w_push && !w_pop && r_count == C_FULL));
      end
   end

endmodule
